// File: rtl/tpm_axil_master.sv
// AXI4-Lite initiator for the tpm_ip register slave.
// Takes one command at a time and returns its completion on a valid/ready response port.
module tpm_axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 9,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [7:0]                      err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

  state_t                            state_q, state_d;
  logic                              cmd_ready_q, cmd_ready_d;
  logic                              awvalid_q, awvalid_d;
  logic                              wvalid_q, wvalid_d;
  logic                              aw_done_q, aw_done_d;
  logic                              w_done_q, w_done_d;
  logic                              bready_q, bready_d;
  logic                              arvalid_q, arvalid_d;
  logic                              rready_q, rready_d;
  logic                              rsp_valid_q, rsp_valid_d;
  logic                              rsp_write_q, rsp_write_d;
  logic [1:0]                        rsp_resp_q, rsp_resp_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [7:0]                        err_count_q, err_count_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;

  logic aw_hs, w_hs;
  logic [7:0] err_count_inc;

  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q & M_AXI_WREADY;
  // Saturating error counter step, applied only on a non-OKAY capture.
  assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
    err_count_d = err_count_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_rdata_d = '0;
          if (M_AXI_BRESP != 2'b00) err_count_d = err_count_inc;
          state_d     = RESP;
        end
      end
      RD_AR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_rdata_d = M_AXI_RDATA;
          if (M_AXI_RRESP != 2'b00) err_count_d = err_count_inc;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_rdata_q <= '0;
      err_count_q <= 8'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_count_q <= err_count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  // Never offer a command slot while reset is being applied.
  assign cmd_ready     = cmd_ready_q & ~M_AXI_ARESET;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign err_count     = err_count_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_tpm_axil_master.sv
// Bench for tpm_axil_master: directed command table against a delay-configurable AXI4-Lite slave model.
module tb_tpm_axil_master;

  logic        clk = 1'b0;
  logic        M_AXI_ARESET;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        cmd_ready, rsp_valid, rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_count;
  logic [8:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [31:0] M_AXI_RDATA = 32'h0;

  tpm_axil_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .err_count(err_count),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model configuration and state
  int          s_aw_dly = 0, s_w_dly = 0, s_b_dly = 0, s_ar_dly = 0, s_r_dly = 0;
  logic [1:0]  s_resp = 2'b00;
  logic [31:0] mem [0:127];
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  logic [8:0]  aw_addr_l = '0, r_addr = '0;
  logic [31:0] w_data_l = '0;
  logic [3:0]  w_strb_l = '0;
  logic        rst_seen = 1'b1;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_bv = 0, p_br = 0;
  logic        p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0;
  logic [8:0]  p_awaddr = '0, p_araddr = '0;
  logic [31:0] p_wdata = '0;
  logic [3:0]  p_wstrb = '0;

  always @(posedge clk) rst_seen = M_AXI_ARESET;

  // Slave acts on the falling edge; handshakes are inferred from the previous falling-edge sample.
  always @(negedge clk) begin
    logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
    hs_aw = p_awv & p_awr;
    hs_w  = p_wv & p_wr;
    hs_b  = p_bv & p_br;
    hs_ar = p_arv & p_arr;
    hs_r  = p_rv & p_rr;
    if (rst_seen) begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    end else begin
      if (p_awv && !p_awr) chk("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, p_awaddr});
      if (p_wv && !p_wr) chk("w_hold", {M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WDATA}, {1'b1, p_wstrb, p_wdata});
      if (p_arv && !p_arr) chk("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, p_araddr});
      if (hs_w) begin
        chk("w_drop", M_AXI_WVALID, 1'b0);
        if (!hs_aw && !aw_got) chk("aw_stays", M_AXI_AWVALID, 1'b1);
        M_AXI_WREADY = 0; w_got = 1; w_data_l = p_wdata; w_strb_l = p_wstrb; w_cnt++; w_wait = 0;
      end else if (M_AXI_WVALID && !M_AXI_WREADY) begin
        if (w_wait >= s_w_dly) M_AXI_WREADY = 1; else w_wait++;
      end
      if (hs_aw) begin
        chk("aw_drop", M_AXI_AWVALID, 1'b0);
        M_AXI_AWREADY = 0; aw_got = 1; aw_addr_l = p_awaddr; aw_cnt++; aw_wait = 0;
      end else if (M_AXI_AWVALID && !M_AXI_AWREADY) begin
        if (aw_wait >= s_aw_dly) M_AXI_AWREADY = 1; else aw_wait++;
      end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (w_strb_l[b]) mem[aw_addr_l[8:2]][8*b +: 8] = w_data_l[8*b +: 8];
        aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
      end
      if (hs_b) begin
        M_AXI_BVALID = 0; b_cnt++;
      end else if (b_pend && !M_AXI_BVALID) begin
        if (b_wait >= s_b_dly) begin M_AXI_BVALID = 1; M_AXI_BRESP = s_resp; b_pend = 0; end
        else b_wait++;
      end
      if (hs_ar) begin
        chk("ar_drop", M_AXI_ARVALID, 1'b0);
        M_AXI_ARREADY = 0; r_pend = 1; r_addr = p_araddr; r_wait = 0; ar_cnt++; ar_wait = 0;
      end else if (M_AXI_ARVALID && !M_AXI_ARREADY) begin
        if (ar_wait >= s_ar_dly) M_AXI_ARREADY = 1; else ar_wait++;
      end
      if (hs_r) begin
        M_AXI_RVALID = 0; r_cnt++;
      end else if (r_pend && !M_AXI_RVALID) begin
        if (r_wait >= s_r_dly) begin
          M_AXI_RVALID = 1; M_AXI_RDATA = mem[r_addr[8:2]]; M_AXI_RRESP = s_resp; r_pend = 0;
        end else r_wait++;
      end
    end
    p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
    p_wv = M_AXI_WVALID;   p_wr = M_AXI_WREADY;   p_wdata = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
    p_bv = M_AXI_BVALID;   p_br = M_AXI_BREADY;
    p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
    p_rv = M_AXI_RVALID;   p_rr = M_AXI_RREADY;
  end

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp;
    int          hold;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_err;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [8:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int awd, input int wd, input int bd,
                              input int ard, input int rd, input logic [1:0] resp, input int hold,
                              input int lat, input logic [31:0] rdata, input logic [7:0] err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
    v.resp = resp; v.hold = hold; v.exp_lat = lat; v.exp_rdata = rdata; v.exp_err = err;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int cnt, lat, a0, w0, b0, ar0, r0;
    logic [34:0] snap;
    s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_b_dly = v.b_dly;
    s_ar_dly = v.ar_dly; s_r_dly = v.r_dly; s_resp = v.resp;
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
    @(negedge clk);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    cnt = 0;
    while (!cmd_ready && cnt < 50) begin @(negedge clk); cnt++; end
    if (!cmd_ready) begin
      chk({tag, " cmd_ready_timeout"}, cmd_ready, 1'b1);
      cmd_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    if (v.wr)
      chk({tag, " aw_w_issue"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB},
          {1'b1, 1'b1, v.addr, v.wdata, v.wstrb});
    else
      chk({tag, " ar_issue"}, {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, v.addr});
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
    if (v.exp_lat != 0) chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " rsp_fields"}, {rsp_write, rsp_resp, rsp_rdata}, {v.wr, v.resp, v.exp_rdata});
    chk({tag, " err_count"}, err_count, v.exp_err);
    snap = {rsp_write, rsp_resp, rsp_rdata};
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({tag, " rsp_hold"}, {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, snap});
      chk({tag, " cmd_ready_busy"}, cmd_ready, 1'b0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, " rsp_done"}, {rsp_valid, cmd_ready}, {1'b0, 1'b1});
    if (v.wr) chk({tag, " hs_counts"}, {aw_cnt - a0, w_cnt - w0, b_cnt - b0, ar_cnt - ar0},
                  {32'd1, 32'd1, 32'd1, 32'd0});
    else      chk({tag, " hs_counts"}, {ar_cnt - ar0, r_cnt - r0, aw_cnt - a0, b_cnt - b0},
                  {32'd1, 32'd1, 32'd0, 32'd0});
  endtask

  vec_t vecs [10];

  initial begin
    int cnt, seen;
    vecs[0] = mk(1, 9'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 3, 32'h0,        8'd0);
    vecs[1] = mk(0, 9'h004, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 3, 32'hDEADBEEF, 8'd0);
    vecs[2] = mk(1, 9'h1FF, 32'h00000012, 4'hF, 3, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0,        8'd0);
    vecs[3] = mk(0, 9'h1FF, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h00000012, 8'd0);
    vecs[4] = mk(1, 9'h010, 32'hA5A5C3C3, 4'hC, 0, 2, 0, 0, 0, 2'b00, 5, 0, 32'h0,        8'd0);
    vecs[5] = mk(0, 9'h010, 32'h0,        4'h0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 32'hA5A50000, 8'd0);
    vecs[6] = mk(1, 9'h020, 32'h11112222, 4'hF, 0, 0, 0, 0, 0, 2'b10, 0, 0, 32'h0,        8'd1);
    vecs[7] = mk(0, 9'h004, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 32'hDEADBEEF, 8'd2);
    vecs[8] = mk(1, 9'h008, 32'h0BADF00D, 4'hF, 1, 1, 4, 0, 0, 2'b00, 0, 0, 32'h0,        8'd2);
    vecs[9] = mk(0, 9'h008, 32'h0,        4'h0, 0, 0, 0, 2, 3, 2'b00, 0, 0, 32'h0BADF00D, 8'd2);

    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    M_AXI_ARESET = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {cmd_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid},
        7'b0);
    chk("reset_values", {rsp_write, rsp_resp, rsp_rdata, err_count, M_AXI_AWADDR, M_AXI_WDATA},
        '0);
    chk("reset_prot", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB, M_AXI_ARADDR}, '0);
    M_AXI_ARESET = 0;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 300; i++)
      run_vec(mk(0, 9'h004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 32'hDEADBEEF,
                 8'((i + 3 > 255) ? 255 : i + 3)), "err_sat");
    chk("err_count_saturated", err_count, 8'd255);

    // Reset while the read data phase is pending.
    s_ar_dly = 0; s_r_dly = 30; s_resp = 2'b00;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 9'h004;
    chk("rst_seq_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    cnt = 0;
    while (!M_AXI_RREADY && cnt < 10) begin @(negedge clk); cnt++; end
    chk("rst_seq_in_rd_r", M_AXI_RREADY, 1'b1);
    M_AXI_ARESET = 1;
    #1;
    chk("cmd_ready_in_reset", cmd_ready, 1'b0);
    @(negedge clk);
    M_AXI_ARESET = 0;
    chk("abandon_outputs", {M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready}, 4'b0);
    chk("abandon_err_count", err_count, 8'd0);
    @(negedge clk);
    chk("cmd_ready_post_reset", cmd_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_abandon", seen, 0);

    run_vec(mk(1, 9'h00C, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 3, 32'h0, 8'd0), "post_rst_wr");
    run_vec(mk(0, 9'h00C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 3, 32'h12345678, 8'd0), "post_rst_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tpm_axil_master.md
# tpm_axil_master

Synthesizable AXI4-Lite initiator that converts single-beat commands from TPM control logic into AXI4-Lite write and read transactions on the tpm_ip register slave. It issues exactly one outstanding transaction at a time. It returns each completion, with its response code and read data, on a valid/ready response port. It sits between the TPM command sequencer and the S00_AXI register-file slave, and replaces bench-only stimulus with synthesizable hardware.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 9, byte address width; matches the slave register space.
- C_M_AXI_DATA_WIDTH, 32, data width; strobe width is C_M_AXI_DATA_WIDTH/8.

Ports:
- M_AXI_ACLK  in  1  single clock for all logic.
- M_AXI_ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- cmd_wstrb  in  DATA_WIDTH/8  write strobes (ignored for reads).
- rsp_valid  out  1  completion available.
- rsp_ready  in  1  completion consumed.
- rsp_write  out  1  the completion belongs to a write.
- rsp_resp  out  2  captured BRESP or RRESP.
- rsp_rdata  out  DATA_WIDTH  captured RDATA; 0 for writes.
- err_count  out  8  count of non-OKAY responses; saturates at 255.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master side.
  - Widths follow the parameters.
  - AWPROT and ARPROT are tied to 3'b000.

## Operation
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE:
  - cmd_ready = 1 only in IDLE with reset deasserted.
  - On cmd_valid & cmd_ready, register addr/wdata/wstrb/write.
  - Go to WR_AW_W on a write, RD_AR on a read.
- WR_AW_W:
  - AWVALID and WVALID are both high on entry.
  - Each channel is tracked by an independent done flag.
  - AWVALID drops the cycle after its AWVALID & AWREADY edge; WVALID does the same on its own handshake.
  - Handshakes may occur in the same cycle or in either order.
  - When both are done, go to WR_B.
- WR_B: BREADY = 1. On BVALID, capture BRESP, set rsp_write = 1 and rsp_rdata = 0, go to RESP.
- RD_AR: ARVALID = 1 until the ARREADY edge, then go to RD_R.
- RD_R: RREADY = 1. On RVALID, capture RDATA and RRESP, set rsp_write = 0, go to RESP.
- RESP:
  - rsp_valid = 1 until the rsp_valid & rsp_ready edge, then go to IDLE.
  - rsp_* fields are held stable while rsp_valid is high.
- err_count increments by 1 on each BVALID/RVALID capture whose resp ≠ 2'b00; it holds at 255.
- AXI rules:
  - VALID never depends on READY.
  - Once asserted, VALID is never withdrawn before its handshake.
  - Address, data and strobe are held stable while VALID is high.

## Timing
- Reset values (M_AXI_ARESET high at an edge), effective next cycle:
  - State = IDLE.
  - AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, cmd_ready = 0.
  - rsp_resp, rsp_rdata, rsp_write, err_count, AWADDR, WDATA, WSTRB, ARADDR = 0.
- cmd_ready is forced low while reset is high.
- Reset mid-transaction abandons the transaction; no response is issued.
- Command accepted at edge N:
  - AWVALID/WVALID or ARVALID are high from cycle N+1 (registered).
- Best-case write, with AWREADY = WREADY = 1 in N+1 and BVALID = 1 in N+2:
  - BREADY is high in N+2.
  - rsp_valid is high in N+3.
- Best-case read, with ARREADY = 1 in N+1 and RVALID = 1 in N+2:
  - rsp_valid is high in N+3.
- Response accepted at edge M: cmd_ready is high in M+1. Throughput is at most one transaction per 4 cycles.
- BREADY/RREADY are only high in WR_B/RD_R. A BVALID/RVALID arriving earlier waits.

## Test plan
- Write 0xDEADBEEF, strb 0xF, to 0x004 with slave readies immediate:
  - AW/W handshake in the same cycle.
  - rsp_valid 3 cycles after cmd accept, rsp_write = 1, rsp_resp = 0, err_count = 0.
- Read 0x004 after the write:
  - ARADDR = 0x004 held until ARREADY.
  - rsp_rdata = 0xDEADBEEF, rsp_resp = 0, rsp_write = 0.
- Write 0x00000012 to 0x1FF with AWREADY delayed 3 cycles after WREADY:
  - WVALID drops after its handshake while AWVALID stays high.
  - Exactly one B handshake; response OKAY.
- Hold rsp_ready low 5 cycles after rsp_valid:
  - rsp_* stable throughout; cmd_ready stays 0.
  - Second command accepted only after the rsp handshake.
- Slave returns BRESP = 2'b10, then RRESP = 2'b11:
  - rsp_resp matches each response.
  - err_count goes 0 → 1 → 2.
  - Force 300 errors: err_count = 255.
- Assert M_AXI_ARESET for 1 cycle while in RD_R:
  - ARVALID/RREADY/rsp_valid = 0 the next cycle; no response issued.
  - cmd_ready = 1 the cycle after reset drops; a new write completes normally.
